map_access_arbiter: RTL and testbench
=====================================

MAP_ACCESS_ARBITER -- requirements
Module: map_access_arbiter

Interface
REQ-001 Parameter: MAP_ROWS, 5, number of map rows; legal row index 0..MAP_ROWS-1.
REQ-002 Parameter: MAP_COLS, 100, number of map columns; legal column index 0..MAP_COLS-1.
REQ-003 Parameter: STARVE_LIMIT, 4, consecutive denied cycles after which requester 1 is forced a grant.
REQ-004 Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- scroll_tick  in  1  advance scroll offset by one column.
- r0_req  in  1  renderer lookup request, high priority.
- r0_row  in  3  renderer row.
- r0_col  in  7  renderer screen-relative column.
- r0_gnt  out  1  renderer request accepted this cycle.
- r0_valid  out  1  renderer response valid, one-cycle pulse.
- r0_rgb  out  12  renderer response colour {r,g,b}.
- r0_state  out  3  renderer response block_state.
- r1_req, r1_row, r1_col, r1_gnt, r1_valid, r1_rgb, r1_state: same widths/meaning for game-logic requester, low priority.
- map_y  out  3  registered row index driven to map lookup.
- map_x  out  7  registered absolute column index driven to map lookup.
- map_r, map_g, map_b  in  4 each  map colour, combinational from map_y/map_x.
- map_block_state  in  3  map block_state, combinational from map_y/map_x.
- scroll_offset  out  7  current scroll offset.

Function
REQ-005 The block SHALL accept at most one request per cycle; gnt outputs SHALL be combinational from req inputs and internal state, never both high.
REQ-006 Default arbitration SHALL grant r0 whenever r0_req is high, else r1 when r1_req is high.
REQ-007 Starve counter SHALL increment each cycle r1_req is high and r1_gnt is low, saturating at STARVE_LIMIT; it SHALL clear when r1_gnt is high or r1_req is low.
REQ-008 When starve counter equals STARVE_LIMIT and r1_req is high, r1 SHALL be granted that cycle regardless of r0_req, and r0_gnt SHALL be low.
REQ-009 Absolute column = (col + scroll_offset) mod MAP_COLS, computed in 8 bits with a single conditional subtract of MAP_COLS; scroll_offset value in the grant cycle SHALL be used.
REQ-010 scroll_offset SHALL increment on each clock with scroll_tick high, wrapping MAP_COLS-1 -> 0; a tick coinciding with a grant SHALL NOT affect that grant's translation.
REQ-011 Pipeline: grant in cycle N; map_y/map_x and requester tag registered at end of N; map outputs sampled at end of N+1; owner's valid high during N+2 with rgb/state held until next response for that requester.
REQ-012 Throughput SHALL be one lookup per cycle; back-to-back grants SHALL each produce their own valid pulse in order, two cycles later.
REQ-013 Request with row >= MAP_ROWS or col >= MAP_COLS SHALL be granted, SHALL NOT change map_y/map_x, and SHALL respond at N+2 with rgb 12'h000, state 3'b111.
REQ-014 Cycles with no grant SHALL hold map_y/map_x and produce no valid pulse.
REQ-015 r0_valid and r1_valid SHALL never be high in the same cycle.

Reset
REQ-016 On clk edge with rst high: scroll_offset=0, starve counter=0, map_y=0, map_x=0, all pipeline stages emptied, r0_valid=r1_valid=0, rgb=0, state=0.
REQ-017 While rst is high r0_gnt and r1_gnt SHALL be 0; lookups in flight when rst asserts SHALL be discarded without a valid pulse.

Verification
REQ-018 Offset 0, r0_req row 1 col 5 one cycle -> r0_gnt same cycle; map_y=1, map_x=5 next cycle; r0_valid two cycles after grant with r0_rgb=12'h0F0, r0_state=3'b000.
REQ-019 r0_req and r1_req held high continuously -> r0 granted 4 cycles, r1 granted 5th, pattern repeats; r1_valid pulses every 5th response.
REQ-020 100 scroll_tick pulses from reset -> scroll_offset 99 after 99 ticks, 0 after 100; at offset 98, r1 col 5 -> map_x=3.
REQ-021 r1_req row 5 col 0 -> r1_valid after 2 cycles, rgb 12'h000, state 3'b111, map_y/map_x unchanged.
REQ-022 rst asserted one cycle after an r0 grant -> no r0_valid pulse; all outputs at reset values the cycle after rst.
REQ-023 scroll_tick coincident with r0 grant at offset 10, col 0 -> map_x=10; scroll_offset=11 next cycle.

Source files
------------

// File: rtl/map_access_arbiter.sv
// map_access_arbiter
//
// Shares one combinational map lookup port between two requesters:
// r0 (renderer, high priority) and r1 (game logic, low priority).
// Each accepted request is translated from a screen-relative column to an
// absolute map column using the current scroll offset. The result is
// presented on map_y/map_x one cycle after the grant. The map colour and
// block state are returned to the owner two cycles after the grant.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   scroll_tick         advance scroll_offset by one column (wraps)
//   rN_req/row/col      lookup request from requester N
//   rN_gnt              request accepted this cycle (combinational)
//   rN_valid            one-cycle response pulse
//   rN_rgb/state        response data, held until the next response for N
//   map_y, map_x        registered lookup address into the map
//   map_r/g/b           map colour (combinational from map_y/map_x)
//   map_block_state     map block state (combinational from map_y/map_x)
//   scroll_offset       current scroll offset
module map_access_arbiter #(
  parameter int MAP_ROWS     = 5,
  parameter int MAP_COLS     = 100,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scroll_tick,
  input  logic        r0_req,
  input  logic [2:0]  r0_row,
  input  logic [6:0]  r0_col,
  output logic        r0_gnt,
  output logic        r0_valid,
  output logic [11:0] r0_rgb,
  output logic [2:0]  r0_state,
  input  logic        r1_req,
  input  logic [2:0]  r1_row,
  input  logic [6:0]  r1_col,
  output logic        r1_gnt,
  output logic        r1_valid,
  output logic [11:0] r1_rgb,
  output logic [2:0]  r1_state,
  output logic [2:0]  map_y,
  output logic [6:0]  map_x,
  input  logic [3:0]  map_r,
  input  logic [3:0]  map_g,
  input  logic [3:0]  map_b,
  input  logic [2:0]  map_block_state,
  output logic [6:0]  scroll_offset
);

  localparam int              SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [3:0]      ROW_LIM    = 4'(MAP_ROWS);
  localparam logic [7:0]      COL_LIM    = 8'(MAP_COLS);
  localparam logic [6:0]      OFF_LAST   = 7'(MAP_COLS - 1);

  logic [SW-1:0] starve_cnt;
  logic          force_r1;
  logic          any_gnt;
  logic [2:0]    sel_row;
  logic [6:0]    sel_col;
  logic [7:0]    col_sum;
  logic [6:0]    abs_col;
  logic          sel_oob;

  // Lookup stage: one entry per accepted request, tagged with its owner
  logic          s1_valid;
  logic          s1_tag;
  logic          s1_oob;

  logic [11:0]   resp_rgb;
  logic [2:0]    resp_state;

  // Once r1 has waited STARVE_LIMIT cycles it overrides r0 for one cycle.
  // Nothing is granted while reset is held.
  assign force_r1 = r1_req && (starve_cnt == STARVE_MAX);
  assign r0_gnt   = !rst && r0_req && !force_r1;
  assign r1_gnt   = !rst && r1_req && (force_r1 || !r0_req);
  assign any_gnt  = r0_gnt || r1_gnt;

  assign sel_row = r1_gnt ? r1_row : r0_row;
  assign sel_col = r1_gnt ? r1_col : r0_col;

  // The sum of a legal column and the offset is below 2*MAP_COLS, so a
  // single conditional subtract is enough to wrap it. The offset register
  // is read here before any tick in this cycle takes effect.
  always_comb begin
    col_sum = {1'b0, sel_col} + {1'b0, scroll_offset};
    if (col_sum >= COL_LIM) begin
      abs_col = 7'(col_sum - COL_LIM);
    end else begin
      abs_col = col_sum[6:0];
    end
    sel_oob = ({1'b0, sel_row} >= ROW_LIM) || ({1'b0, sel_col} >= COL_LIM);
  end

  // Out-of-range requests return a fixed "nothing here" answer instead of
  // map data.
  always_comb begin
    if (s1_oob) begin
      resp_rgb   = 12'h000;
      resp_state = 3'b111;
    end else begin
      resp_rgb   = {map_r, map_g, map_b};
      resp_state = map_block_state;
    end
  end

  // Starvation counter for r1: it counts denied cycles and saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!r1_req || r1_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scroll_offset <= '0;
    end else if (scroll_tick) begin
      scroll_offset <= (scroll_offset == OFF_LAST) ? 7'd0 : scroll_offset + 7'd1;
    end
  end

  // Address stage: the map address only moves for legal grants, so idle
  // cycles and out-of-range requests leave the map port untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_tag   <= 1'b0;
      s1_oob   <= 1'b0;
      map_y    <= '0;
      map_x    <= '0;
    end else begin
      s1_valid <= any_gnt;
      s1_tag   <= r1_gnt;
      s1_oob   <= sel_oob;
      if (any_gnt && !sel_oob) begin
        map_y <= sel_row;
        map_x <= abs_col;
      end
    end
  end

  // Response stage: the owner's data registers update only on its own
  // response. Only one stage-1 entry exists, so the two valids are exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r0_valid <= 1'b0;
      r1_valid <= 1'b0;
      r0_rgb   <= '0;
      r0_state <= '0;
      r1_rgb   <= '0;
      r1_state <= '0;
    end else begin
      r0_valid <= s1_valid && !s1_tag;
      r1_valid <= s1_valid && s1_tag;
      if (s1_valid && !s1_tag) begin
        r0_rgb   <= resp_rgb;
        r0_state <= resp_state;
      end
      if (s1_valid && s1_tag) begin
        r1_rgb   <= resp_rgb;
        r1_state <= resp_state;
      end
    end
  end

endmodule

// File: tb/tb_map_access_arbiter.sv
// tb_map_access_arbiter
//
// Directed bench for map_access_arbiter. A small behavioural map answers
// lookups combinationally from map_y/map_x. Each scenario task drives its
// own vectors and compares against hand-derived values.
module tb_map_access_arbiter;

  logic        clk;
  logic        rst;
  logic        scroll_tick;
  logic        r0_req, r1_req;
  logic [2:0]  r0_row, r1_row;
  logic [6:0]  r0_col, r1_col;
  logic        r0_gnt, r1_gnt, r0_valid, r1_valid;
  logic [11:0] r0_rgb, r1_rgb;
  logic [2:0]  r0_state, r1_state;
  logic [2:0]  map_y;
  logic [6:0]  map_x;
  logic [3:0]  map_r, map_g, map_b;
  logic [2:0]  map_block_state;
  logic [6:0]  scroll_offset;

  int checks   = 0;
  int failures = 0;

  map_access_arbiter #(.MAP_ROWS(5), .MAP_COLS(100), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .scroll_tick(scroll_tick),
    .r0_req(r0_req), .r0_row(r0_row), .r0_col(r0_col), .r0_gnt(r0_gnt),
    .r0_valid(r0_valid), .r0_rgb(r0_rgb), .r0_state(r0_state),
    .r1_req(r1_req), .r1_row(r1_row), .r1_col(r1_col), .r1_gnt(r1_gnt),
    .r1_valid(r1_valid), .r1_rgb(r1_rgb), .r1_state(r1_state),
    .map_y(map_y), .map_x(map_x), .map_r(map_r), .map_g(map_g), .map_b(map_b),
    .map_block_state(map_block_state), .scroll_offset(scroll_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Map contents: {rgb, state}. Cell (1,5) is green / state 0; other cells
  // encode their own coordinates so that misaddressed lookups show up.
  function automatic logic [14:0] tb_map(input logic [2:0] y, input logic [6:0] x);
    if (y == 3'd1 && x == 7'd5) return {12'h0F0, 3'b000};
    return {x[3:0], 1'b0, y, 1'b0, x[6:4], x[2:0] ^ y};
  endfunction

  always_comb {map_r, map_g, map_b, map_block_state} = tb_map(map_y, map_x);

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; r0_req = 1'b1; r1_req = 1'b1;
    #1;
    checks++; if (r0_gnt !== 1'b0) begin failures++; $display("[TB] FAIL reset_r0_gnt: got %b want 0", r0_gnt); end
    checks++; if (r1_gnt !== 1'b0) begin failures++; $display("[TB] FAIL reset_r1_gnt: got %b want 0", r1_gnt); end
    next_cycle();
    next_cycle();
    rst = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
    #1;
    checks++; if (scroll_offset !== 7'd0) begin failures++; $display("[TB] FAIL reset_offset: got %0d want 0", scroll_offset); end
    checks++; if ({map_y, map_x} !== 10'd0) begin failures++; $display("[TB] FAIL reset_map_addr: got y=%0d x=%0d want 0/0", map_y, map_x); end
    checks++; if ({r0_valid, r1_valid} !== 2'b00) begin failures++; $display("[TB] FAIL reset_valid: got %b want 00", {r0_valid, r1_valid}); end
    checks++; if ({r0_rgb, r0_state, r1_rgb, r1_state} !== 30'd0) begin failures++; $display("[TB] FAIL reset_data: got %h/%h %h/%h want zeros", r0_rgb, r0_state, r1_rgb, r1_state); end
    next_cycle();
  endtask

  task automatic test_basic();
    r0_req = 1'b1; r0_row = 3'd1; r0_col = 7'd5;
    #1;
    checks++; if ({r0_gnt, r1_gnt} !== 2'b10) begin failures++; $display("[TB] FAIL basic_gnt: got %b want 10", {r0_gnt, r1_gnt}); end
    next_cycle();
    r0_req = 1'b0;
    checks++; if (map_y !== 3'd1 || map_x !== 7'd5) begin failures++; $display("[TB] FAIL basic_addr: got y=%0d x=%0d want 1/5", map_y, map_x); end
    checks++; if (r0_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_early_valid: got %b want 0", r0_valid); end
    next_cycle();
    checks++; if (r0_valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_valid: got %b want 1", r0_valid); end
    checks++; if (r0_rgb !== 12'h0F0 || r0_state !== 3'b000) begin failures++; $display("[TB] FAIL basic_data: got %h/%b want 0f0/000", r0_rgb, r0_state); end
    next_cycle();
    checks++; if (r0_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_pulse: got %b want 0", r0_valid); end
    checks++; if (r0_rgb !== 12'h0F0) begin failures++; $display("[TB] FAIL basic_hold: got %h want 0f0", r0_rgb); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  rows [3] = '{3'd1, 3'd2, 3'd4};
    logic [6:0]  cols [3] = '{7'd5, 7'd10, 7'd99};
    logic [14:0] m;
    for (int i = 0; i < 5; i++) begin
      r0_req = (i < 3);
      if (i < 3) begin r0_row = rows[i]; r0_col = cols[i]; end
      #1;
      if (i >= 2) begin
        m = tb_map(rows[i-2], cols[i-2]);
        checks++; if (r0_valid !== 1'b1 || r1_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_valid%0d: got r0=%b r1=%b want 1/0", i-2, r0_valid, r1_valid); end
        checks++; if ({r0_rgb, r0_state} !== m) begin failures++; $display("[TB] FAIL b2b_data%0d: got %h want %h", i-2, {r0_rgb, r0_state}, m); end
      end
      next_cycle();
    end
    checks++; if (r0_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_tail: got %b want 0", r0_valid); end
  endtask

  task automatic test_starvation();
    logic [14:0] m;
    logic        exp_r1;
    int          k;
    r0_row = 3'd0; r1_row = 3'd2;
    for (int i = 0; i < 12; i++) begin
      r0_req = (i < 10); r1_req = (i < 10);
      r0_col = 7'(i); r1_col = 7'(50 + i);
      #1;
      if (i < 10) begin
        exp_r1 = ((i % 5) == 4);
        checks++; if ({r0_gnt, r1_gnt} !== {!exp_r1, exp_r1}) begin failures++; $display("[TB] FAIL starve_gnt%0d: got %b want %b", i, {r0_gnt, r1_gnt}, {!exp_r1, exp_r1}); end
      end
      if (i >= 2) begin
        k = i - 2;
        exp_r1 = ((k % 5) == 4);
        checks++; if ({r0_valid, r1_valid} !== {!exp_r1, exp_r1}) begin failures++; $display("[TB] FAIL starve_valid%0d: got %b want %b", k, {r0_valid, r1_valid}, {!exp_r1, exp_r1}); end
        if (exp_r1) begin
          m = tb_map(3'd2, 7'(50 + k));
          checks++; if ({r1_rgb, r1_state} !== m) begin failures++; $display("[TB] FAIL starve_data%0d: got %h want %h", k, {r1_rgb, r1_state}, m); end
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_out_of_range();
    r1_req = 1'b1; r1_row = 3'd5; r1_col = 7'd0;
    #1;
    checks++; if (r1_gnt !== 1'b1) begin failures++; $display("[TB] FAIL oob_r1_gnt: got %b want 1", r1_gnt); end
    next_cycle();
    r1_req = 1'b0;
    r0_req = 1'b1; r0_row = 3'd0; r0_col = 7'd100;
    #1;
    checks++; if (r0_gnt !== 1'b1) begin failures++; $display("[TB] FAIL oob_r0_gnt: got %b want 1", r0_gnt); end
    checks++; if (map_y !== 3'd2 || map_x !== 7'd59) begin failures++; $display("[TB] FAIL oob_row_addr: got y=%0d x=%0d want 2/59", map_y, map_x); end
    next_cycle();
    r0_req = 1'b0;
    checks++; if (map_y !== 3'd2 || map_x !== 7'd59) begin failures++; $display("[TB] FAIL oob_col_addr: got y=%0d x=%0d want 2/59", map_y, map_x); end
    checks++; if (r1_valid !== 1'b1 || r0_valid !== 1'b0) begin failures++; $display("[TB] FAIL oob_r1_valid: got r1=%b r0=%b want 1/0", r1_valid, r0_valid); end
    checks++; if (r1_rgb !== 12'h000 || r1_state !== 3'b111) begin failures++; $display("[TB] FAIL oob_r1_data: got %h/%b want 000/111", r1_rgb, r1_state); end
    next_cycle();
    checks++; if (r0_valid !== 1'b1 || r1_valid !== 1'b0) begin failures++; $display("[TB] FAIL oob_r0_valid: got r0=%b r1=%b want 1/0", r0_valid, r1_valid); end
    checks++; if (r0_rgb !== 12'h000 || r0_state !== 3'b111) begin failures++; $display("[TB] FAIL oob_r0_data: got %h/%b want 000/111", r0_rgb, r0_state); end
    next_cycle();
  endtask

  task automatic test_flush();
    r0_req = 1'b1; r0_row = 3'd1; r0_col = 7'd5;
    next_cycle();
    rst = 1'b1;
    #1;
    checks++; if (r0_gnt !== 1'b0) begin failures++; $display("[TB] FAIL flush_gnt_in_rst: got %b want 0", r0_gnt); end
    next_cycle();
    rst = 1'b0; r0_req = 1'b0;
    checks++; if (r0_valid !== 1'b0 || r1_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid: got %b%b want 00", r0_valid, r1_valid); end
    checks++; if ({map_y, map_x, scroll_offset} !== 17'd0) begin failures++; $display("[TB] FAIL flush_regs: got y=%0d x=%0d off=%0d want 0", map_y, map_x, scroll_offset); end
    checks++; if ({r0_rgb, r0_state, r1_rgb, r1_state} !== 30'd0) begin failures++; $display("[TB] FAIL flush_data: got %h/%h %h/%h want zeros", r0_rgb, r0_state, r1_rgb, r1_state); end
    next_cycle();
    checks++; if (r0_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_late_valid: got %b want 0", r0_valid); end
  endtask

  task automatic test_scroll();
    logic [14:0] m;
    scroll_tick = 1'b1;
    repeat (99) next_cycle();
    checks++; if (scroll_offset !== 7'd99) begin failures++; $display("[TB] FAIL scroll_99: got %0d want 99", scroll_offset); end
    next_cycle();
    checks++; if (scroll_offset !== 7'd0) begin failures++; $display("[TB] FAIL scroll_wrap: got %0d want 0", scroll_offset); end
    repeat (98) next_cycle();
    scroll_tick = 1'b0;
    checks++; if (scroll_offset !== 7'd98) begin failures++; $display("[TB] FAIL scroll_98: got %0d want 98", scroll_offset); end
    r1_req = 1'b1; r1_row = 3'd0; r1_col = 7'd5;
    next_cycle();
    r1_req = 1'b0;
    checks++; if (map_y !== 3'd0 || map_x !== 7'd3) begin failures++; $display("[TB] FAIL scroll_xlate: got y=%0d x=%0d want 0/3", map_y, map_x); end
    next_cycle();
    m = tb_map(3'd0, 7'd3);
    checks++; if (r1_valid !== 1'b1 || {r1_rgb, r1_state} !== m) begin failures++; $display("[TB] FAIL scroll_resp: got v=%b %h want 1 %h", r1_valid, {r1_rgb, r1_state}, m); end
  endtask

  task automatic test_tick_with_grant();
    scroll_tick = 1'b1;
    repeat (12) next_cycle();
    checks++; if (scroll_offset !== 7'd10) begin failures++; $display("[TB] FAIL tick_pre_offset: got %0d want 10", scroll_offset); end
    r0_req = 1'b1; r0_row = 3'd3; r0_col = 7'd0;
    #1;
    checks++; if (r0_gnt !== 1'b1) begin failures++; $display("[TB] FAIL tick_gnt: got %b want 1", r0_gnt); end
    next_cycle();
    scroll_tick = 1'b0; r0_req = 1'b0;
    checks++; if (map_y !== 3'd3 || map_x !== 7'd10) begin failures++; $display("[TB] FAIL tick_xlate: got y=%0d x=%0d want 3/10", map_y, map_x); end
    checks++; if (scroll_offset !== 7'd11) begin failures++; $display("[TB] FAIL tick_offset: got %0d want 11", scroll_offset); end
    next_cycle();
    next_cycle();
  endtask

  initial begin
    rst = 1'b1; scroll_tick = 1'b0;
    r0_req = 1'b0; r0_row = '0; r0_col = '0;
    r1_req = 1'b0; r1_row = '0; r1_col = '0;
    #2;
    test_reset();
    test_basic();
    test_back_to_back();
    test_starvation();
    test_out_of_range();
    test_flush();
    test_scroll();
    test_tick_with_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
